// File: rtl/display_pager_if.sv
// Bundle between the BCD source and the pager, plus the pager's outputs toward
// the three seven-segment decoders (HEX2..HEX0).
interface display_pager_if;
    // load is a valid-only strobe: bcd_in/sign_in are taken on every cycle load=1; the pager is always ready.
    logic        en;
    logic        load;
    logic [35:0] bcd_in;
    logic        sign_in;
    logic [11:0] seg_bcd;
    logic [1:0]  page;
    logic        frame_done;

    modport master (
        output en, load, bcd_in, sign_in,
        input  seg_bcd, page, frame_done
    );

    modport slave (
        input  en, load, bcd_in, sign_in,
        output seg_bcd, page, frame_done
    );
endinterface

// File: rtl/display_pager.sv
// Pages a signed nine-digit BCD value over a three-digit display as SIGN/HI/MID/LO,
// latching a whole value per frame, with leading-zero blanking and bad-digit flagging.
module display_pager #(
    parameter int unsigned DWELL_CYCLES = 50000000,
    parameter int unsigned CNT_W        = 26,
    parameter logic [3:0]  BLANK_CODE   = 4'hF,
    parameter logic [3:0]  MINUS_CODE   = 4'hA,
    parameter logic [3:0]  ERR_CODE     = 4'hE
) (
    input  logic            clk,
    input  logic            rst,
    display_pager_if.slave  bus
);

    typedef enum logic [1:0] {
        PG_SIGN = 2'd0,
        PG_HI   = 2'd1,
        PG_MID  = 2'd2,
        PG_LO   = 2'd3
    } page_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

    page_t            r_page;
    logic [CNT_W-1:0] r_cnt;
    logic [35:0]      r_shown;
    logic             r_shown_sign;
    logic [35:0]      r_pend;
    logic             r_pend_sign;
    logic [11:0]      r_seg;
    logic             r_frame_done;

    logic        w_last;
    logic        w_advance;
    logic        w_wrap;
    page_t       w_next_page;
    logic [35:0] w_src_val;
    logic        w_src_sign;

    // Scan from the top digit down; zeros stay dark until the first nonzero (or bad) digit.
    function automatic logic [35:0] fmt_digits(input logic [35:0] v);
        logic [35:0] res;
        logic        seen;
        logic [3:0]  d;
        res  = '0;
        seen = 1'b0;
        for (int k = 8; k >= 0; k--) begin
            d = v[4*k +: 4];
            if (d > 4'd9) begin
                res[4*k +: 4] = ERR_CODE;
                seen          = 1'b1;
            end else if ((d == 4'd0) && !seen && (k != 0)) begin
                res[4*k +: 4] = BLANK_CODE;
            end else begin
                res[4*k +: 4] = d;
                if (d != 4'd0) seen = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [11:0] page_seg(input page_t p, input logic [35:0] v, input logic s);
        logic [35:0] f;
        logic [11:0] res;
        f = fmt_digits(v);
        case (p)
            PG_SIGN: res = (s && (v != '0)) ? {BLANK_CODE, BLANK_CODE, MINUS_CODE}
                                            : {3{BLANK_CODE}};
            PG_HI:   res = f[35:24];
            PG_MID:  res = f[23:12];
            default: res = f[11:0];
        endcase
        return res;
    endfunction

    assign w_last      = (r_cnt == LAST_CNT);
    assign w_advance   = bus.en && w_last;
    assign w_wrap      = w_advance && (r_page == PG_LO);
    assign w_next_page = page_t'(r_page + 2'd1);

    // On a wrap the display must already show the incoming value; a same-cycle load bypasses pending.
    assign w_src_val  = w_wrap ? (bus.load ? bus.bcd_in  : r_pend)      : r_shown;
    assign w_src_sign = w_wrap ? (bus.load ? bus.sign_in : r_pend_sign) : r_shown_sign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_page       <= PG_SIGN;
            r_cnt        <= '0;
            r_shown      <= '0;
            r_shown_sign <= 1'b0;
            r_pend       <= '0;
            r_pend_sign  <= 1'b0;
            r_seg        <= {3{BLANK_CODE}};
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (bus.load) begin
                r_pend      <= bus.bcd_in;
                r_pend_sign <= bus.sign_in;
            end
            if (bus.en) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_advance) begin
                r_page       <= w_next_page;
                r_shown      <= w_src_val;
                r_shown_sign <= w_src_sign;
                r_seg        <= page_seg(w_next_page, w_src_val, w_src_sign);
            end
        end
    end

    assign bus.seg_bcd    = r_seg;
    assign bus.page       = r_page;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_display_pager.sv
// Bench for display_pager with a short dwell: directed frame sequence followed by
// randomized load/enable/reset traffic against a frame-level reference model.
module tb_display_pager;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    display_pager_if bus ();

    display_pager #(
        .DWELL_CYCLES(D),
        .CNT_W       (26),
        .BLANK_CODE  (4'hF),
        .MINUS_CODE  (4'hA),
        .ERR_CODE    (4'hE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: enabled cycles since reset decide the page; value swaps once per frame
    int unsigned m_e;
    logic [35:0] m_shown, m_pend;
    logic        m_ssign, m_psign, m_fd;
    logic [14:0] exp_q[$];

    function automatic logic [11:0] ref_seg(input int p, input logic [35:0] v, input logic s);
        int          msd;
        int          k;
        logic [3:0]  d;
        logic [11:0] r;
        msd = -1;
        r   = '0;
        for (int i = 0; i < 9; i++)
            if (v[4*i +: 4] != 4'd0) msd = i;
        if (p == 0) return (s && msd >= 0) ? 12'hFFA : 12'hFFF;
        for (int j = 0; j < 3; j++) begin
            k = 3 * (3 - p) + j;
            d = v[4*k +: 4];
            if (d > 4'd9)                 r[4*j +: 4] = 4'hE;
            else if (k > msd && k != 0)   r[4*j +: 4] = 4'hF;
            else                          r[4*j +: 4] = d;
        end
        return r;
    endfunction

    function automatic logic [35:0] rand_bcd();
        logic [35:0] v;
        int          nd;
        v  = '0;
        nd = $urandom_range(0, 9);
        for (int i = 0; i < nd; i++)
            v[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: one clock with the given inputs, model update, then scoreboard compare
    task automatic cycle(input logic r, input logic e, input logic l,
                         input logic [35:0] b, input logic s);
        logic [14:0] x;
        @(negedge clk);
        rst         = r;
        bus.en      = e;
        bus.load    = l;
        bus.bcd_in  = b;
        bus.sign_in = s;
        @(posedge clk);
        if (r) begin
            m_e = 0; m_shown = '0; m_ssign = 1'b0; m_pend = '0; m_psign = 1'b0; m_fd = 1'b0;
        end else begin
            m_fd = 1'b0;
            if (e) begin
                m_e++;
                if (m_e % (4 * D) == 0) begin
                    m_fd    = 1'b1;
                    m_shown = l ? b : m_pend;
                    m_ssign = l ? s : m_psign;
                end
            end
            if (l) begin
                m_pend  = b;
                m_psign = s;
            end
        end
        exp_q.push_back({2'((m_e / D) % 4), ref_seg(int'((m_e / D) % 4), m_shown, m_ssign), m_fd});
        #1;
        x = exp_q.pop_front();
        chk("page",       {34'd0, bus.page},       {34'd0, x[14:13]});
        chk("seg_bcd",    {24'd0, bus.seg_bcd},    {24'd0, x[12:1]});
        chk("frame_done", {35'd0, bus.frame_done}, {35'd0, x[0]});
    endtask

    task automatic run(input int n, input logic e);
        for (int i = 0; i < n; i++) cycle(1'b0, e, 1'b0, 36'd0, 1'b0);
    endtask

    initial begin
        bus.en = 1'b0; bus.load = 1'b0; bus.bcd_in = '0; bus.sign_in = 1'b0;
        m_e = 0; m_shown = '0; m_ssign = 1'b0; m_pend = '0; m_psign = 1'b0; m_fd = 1'b0;

        // reset and idle
        cycle(1'b1, 1'b0, 1'b0, 36'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 36'd0, 1'b0);
        chk("rst_seg", {24'd0, bus.seg_bcd}, 36'hFFF);
        chk("rst_page", {34'd0, bus.page}, 36'd0);
        chk("rst_fd", {35'd0, bus.frame_done}, 36'd0);
        run(10, 1'b0);
        chk("idle_seg", {24'd0, bus.seg_bcd}, 36'hFFF);

        // zero frame, with a value queued for the next frame
        run(4, 1'b1);
        chk("zero_hi_page", {34'd0, bus.page}, 36'd1);
        cycle(1'b0, 1'b1, 1'b1, 36'h000012345, 1'b0);
        run(7, 1'b1);
        chk("zero_lo", {24'd0, bus.seg_bcd}, 36'hFF0);
        run(3, 1'b1);
        chk("fd_c15", {35'd0, bus.frame_done}, 36'd0);
        run(1, 1'b1);
        chk("fd_c16", {35'd0, bus.frame_done}, 36'd1);

        // frame 2: positive value, late load must not disturb it
        run(8, 1'b1);
        chk("pos_mid", {24'd0, bus.seg_bcd}, 36'hF12);
        cycle(1'b0, 1'b1, 1'b1, 36'h111111111, 1'b0);
        run(3, 1'b1);
        chk("pos_lo", {24'd0, bus.seg_bcd}, 36'h345);
        run(8, 1'b1);
        chk("ones_hi", {24'd0, bus.seg_bcd}, 36'h111);

        // negative value, then negative zero
        cycle(1'b0, 1'b1, 1'b1, 36'h000000007, 1'b1);
        run(11, 1'b1);
        chk("neg_sign", {24'd0, bus.seg_bcd}, 36'hFFA);
        run(12, 1'b1);
        chk("neg_lo", {24'd0, bus.seg_bcd}, 36'hFF7);
        cycle(1'b0, 1'b1, 1'b1, 36'h000000000, 1'b1);
        run(3, 1'b1);
        chk("negzero_sign", {24'd0, bus.seg_bcd}, 36'hFFF);

        // freeze at MID dwell count 1
        run(9, 1'b1);
        run(10, 1'b0);
        chk("freeze_page", {34'd0, bus.page}, 36'd2);
        run(2, 1'b1);
        chk("resume_mid", {34'd0, bus.page}, 36'd2);
        run(1, 1'b1);
        chk("resume_lo", {34'd0, bus.page}, 36'd3);

        // load on the exact wrap cycle bypasses pending
        run(3, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 36'h00000000C, 1'b0);
        chk("coll_fd", {35'd0, bus.frame_done}, 36'd1);
        run(12, 1'b1);
        chk("coll_lo", {24'd0, bus.seg_bcd}, 36'hFFE);

        // reset mid-frame discards pending
        cycle(1'b0, 1'b1, 1'b1, 36'h987654321, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 36'd0, 1'b0);
        chk("mrst_seg", {24'd0, bus.seg_bcd}, 36'hFFF);
        run(16, 1'b1);
        run(12, 1'b1);
        chk("mrst_lo", {24'd0, bus.seg_bcd}, 36'hFF0);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0, rand_bcd(), 1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_pager.md
Name: display_pager

Overview:
- Output stage downstream of the binary-to-BCD converter in the FIR demo datapath.
- Takes the nine-digit BCD magnitude and sign of the moving-average result and pages it across the three-digit seven-segment group (HEX2..HEX0) in four timed pages: SIGN, HI, MID, LO.
- Latches a whole value per display frame, so one frame never mixes old and new digits.
- Applies leading-zero blanking and flags invalid BCD digits. Its outputs drive three BCD-to-7-segment decoders.

Parameters:
- DWELL_CYCLES, 50000000, clock cycles each page is held (1 s at 50 MHz); legal range 1 to 2^CNT_W.
- CNT_W, 26, width of the dwell counter.
- BLANK_CODE, 4'hF, digit code the decoder renders as dark.
- MINUS_CODE, 4'hA, digit code the decoder renders as "-".
- ERR_CODE, 4'hE, digit code substituted for any input digit greater than 9.

Ports:
- clk  in  1  system clock (CLOCK_50 domain); the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable (the start/stop toggle); low freezes paging.
- load  in  1  one-cycle strobe: bcd_in and sign_in are valid this cycle.
- bcd_in  in  36  nine BCD digits; digit k is at [4k+3:4k]; digit 8 is most significant.
- sign_in  in  1  1 = value is negative.
- seg_bcd  out  12  [11:8] left digit, [7:4] middle digit, [3:0] right digit.
- page  out  2  current page: 0 = SIGN, 1 = HI, 2 = MID, 3 = LO.
- frame_done  out  1  one-cycle pulse on each LO-to-SIGN wrap.

Behaviour:
- Reset (sampled on the clk edge): page=0, dwell counter=0, shown and pending values=0, shown and pending signs=0, seg_bcd=12'hFFF, frame_done=0.
- Capture: load=1 writes bcd_in and sign_in into the pending register. This happens regardless of en and page. The last load before a wrap wins.
- Dwell counter: increments on each cycle with en=1. When it reaches DWELL_CYCLES-1 with en=1, it clears to 0 and page advances 0→1→2→3→0.
- en=0: counter, page, shown value and seg_bcd all hold. Capture into pending still operates. On resume, the remaining dwell count of the current page completes.
- Wrap (page 3 → 0):
  - The shown value and sign load from pending.
  - If load=1 on the same cycle, bcd_in and sign_in bypass pending and load directly into shown.
  - frame_done is asserted for exactly that cycle.
- Outputs: page and seg_bcd are registered and change on the same clock edge. seg_bcd always reflects the new page and the shown value.
- Digit mapping:
  - SIGN page: {BLANK, BLANK, MINUS} when the shown sign is 1 and the shown magnitude is nonzero; otherwise {BLANK, BLANK, BLANK}.
  - HI page: digits 8, 7, 6.
  - MID page: digits 5, 4, 3.
  - LO page: digits 2, 1, 0.
- Leading-zero blanking: every zero digit above the most significant nonzero digit is shown as BLANK_CODE. Digit 0 is never blanked, so a zero value shows ...FF0 on the LO page.
- Invalid digits: any digit greater than 9 is shown as ERR_CODE. It counts as nonzero for the blanking and sign rules.
- DWELL_CYCLES=1: the page advances on every enabled cycle, and frame_done fires every 4th enabled cycle.
- rst asserted mid-frame: the reset state is taken on the next edge and pending is discarded. The first frame after reset shows zero.

Test Plan (DWELL_CYCLES=4):
- Reset: hold rst for 2 cycles, en=0 → seg_bcd=12'hFFF, page=0, frame_done=0. Keep en=0 for 10 cycles → no change.
- Zero frame: en=1, no load → pages SIGN/HI/MID/LO give FFF/FFF/FFF/FF0, each held 4 cycles; frame_done pulses once, on cycle 16.
- Positive value: load bcd_in=36'h000012345, sign=0, during frame 1 → frame 2 shows FFF, FFF, F12, 345. A later load of 36'h111111111 during frame-2 MID leaves frame 2 unchanged; frame 3 shows FFF, 111, 111, 111.
- Negative value: load 36'h000000007, sign=1 → frame shows FFA, FFF, FFF, FF7. Loading zero with sign=1 → SIGN page shows FFF.
- Freeze: drop en for 10 cycles at dwell count 1 of the MID page → page and seg_bcd stable throughout. After en returns, MID lasts exactly 3 more enabled cycles.
- Wrap collision: assert load with bcd_in=36'h00000000C on the exact wrap cycle → the next frame's LO page shows FFE, and pending is not consulted.
